// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the memory port arbiter, its two requesters (CPU, DMA/loader)
// and the single-port synchronous data memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dma_req;
  logic              dma_we;
  logic              dma_lock;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_addr, mem_wdata, mem_we, mem_re,
    input  mem_rdata
  );

  // Requesters plus memory model side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_re,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port data memory between the CPU (default priority) and a
// DMA/debug loader with bounded starvation, lockable DMA bursts and tagged read return.
module mem_port_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MAX_WAIT  = 4,
  parameter int MAX_BURST = 4
) (
  input logic              clock,
  input logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam logic [WAIT_W-1:0]  WAIT_MAX  = WAIT_W'(MAX_WAIT);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_OWN  = 2'd1,
    DMA_OWN  = 2'd2,
    DMA_LOCK = 2'd3
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [BURST_W-1:0] burst_cnt;

  logic cpu_grant;
  logic dma_grant;
  logic read_strobe;
  logic rd_vld_p1;
  logic rd_dma_p1;

  function automatic logic [WAIT_W-1:0] wait_sat_inc(input logic [WAIT_W-1:0] v);
    return (v == WAIT_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [BURST_W-1:0] burst_sat_inc(input logic [BURST_W-1:0] v);
    return (v == BURST_MAX) ? v : v + 1'b1;
  endfunction

  // Arbitration and next state; reset suppresses every grant for that cycle
  always_comb begin
    cpu_grant  = 1'b0;
    dma_grant  = 1'b0;
    state_next = IDLE;

    if (state == DMA_LOCK && bus.dma_req) begin
      if (burst_cnt == BURST_MAX && bus.cpu_req) cpu_grant = 1'b1;
      else                                       dma_grant = 1'b1;
    end else if (bus.cpu_req && bus.dma_req) begin
      if (wait_cnt == WAIT_MAX) dma_grant = 1'b1;
      else                      cpu_grant = 1'b1;
    end else if (bus.cpu_req) begin
      cpu_grant = 1'b1;
    end else if (bus.dma_req) begin
      dma_grant = 1'b1;
    end

    if (reset) begin
      cpu_grant = 1'b0;
      dma_grant = 1'b0;
    end

    if (cpu_grant)      state_next = CPU_OWN;
    else if (dma_grant) state_next = bus.dma_lock ? DMA_LOCK : DMA_OWN;
    else                state_next = IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Starvation counter: only counts cycles in which the DMA is actually asking
  always_ff @(posedge clock) begin
    if (reset)                             wait_cnt <= '0;
    else if (dma_grant)                    wait_cnt <= '0;
    else if (bus.dma_req)                  wait_cnt <= wait_sat_inc(wait_cnt);
  end

  // Burst counter counts locked grants that held the CPU off
  always_ff @(posedge clock) begin
    if (reset)                             burst_cnt <= '0;
    else if (cpu_grant)                    burst_cnt <= '0;
    else if (state_next != DMA_LOCK)       burst_cnt <= '0;
    else if (dma_grant && bus.cpu_req)     burst_cnt <= burst_sat_inc(burst_cnt);
  end

  assign bus.cpu_gnt = cpu_grant;
  assign bus.dma_gnt = dma_grant;

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (cpu_grant) begin
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end else if (dma_grant) begin
      bus.mem_addr  = bus.dma_addr;
      bus.mem_wdata = bus.dma_wdata;
    end
  end

  assign bus.mem_we  = (cpu_grant & bus.cpu_we) | (dma_grant & bus.dma_we);
  assign read_strobe = (cpu_grant & ~bus.cpu_we) | (dma_grant & ~bus.dma_we);
  assign bus.mem_re  = read_strobe;

  // ---- p0 -> p1: read tag follows the memory's one-cycle read latency ----
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_vld_p1 <= 1'b0;
      rd_dma_p1 <= 1'b0;
    end else begin
      rd_vld_p1 <= read_strobe;
      rd_dma_p1 <= dma_grant;
    end
  end

  assign bus.cpu_rvalid = rd_vld_p1 & ~rd_dma_p1 & ~reset;
  assign bus.dma_rvalid = rd_vld_p1 &  rd_dma_p1 & ~reset;
  assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_rdata : '0;
  assign bus.dma_rdata  = bus.dma_rvalid ? bus.mem_rdata : '0;

  a_one_grant: assert property (@(posedge clock) !(bus.cpu_gnt && bus.dma_gnt));
  a_one_rvalid: assert property (@(posedge clock) !(bus.cpu_rvalid && bus.dma_rvalid));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed vector table plus hand sequences and a random scoreboard run for mem_port_arbiter.
module tb_mem_port_arbiter;

  localparam int MAX_WAIT  = 4;
  localparam int MAX_BURST = 4;

  logic clock;
  logic reset;
  logic preload;
  logic [7:0] mem [256];
  logic [7:0] mem_rdata_q;

  int checks;
  int failures;

  mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  mem_port_arbiter #(
    .ADDR_W(8), .DATA_W(8), .MAX_WAIT(MAX_WAIT), .MAX_BURST(MAX_BURST)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] init_val(input logic [7:0] a);
    case (a)
      8'h10:   return 8'h5A;
      8'h01:   return 8'h11;
      8'h02:   return 8'h22;
      8'h30:   return 8'h33;
      default: return 8'h00;
    endcase
  endfunction

  // Synchronous single-port memory model with one-cycle read latency
  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
    if (bus.mem_re) mem_rdata_q <= mem[bus.mem_addr];
  end
  assign bus.mem_rdata = mem_rdata_q;

  typedef struct {
    logic       rst;
    logic [1:0] cpu_rw;     // {req, we}
    logic [7:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic [2:0] dma_rwl;    // {req, we, lock}
    logic [7:0] dma_addr;
    logic [7:0] dma_wdata;
    logic [3:0] strb;       // {cpu_gnt, dma_gnt, mem_we, mem_re}
    logic [7:0] maddr;
    logic [7:0] mwdata;
    logic       crv;
    logic [7:0] crd;
    logic       drv;
    logic [7:0] drd;
  } vec_t;

  vec_t vecs [23];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] observed();
    return 64'({bus.cpu_gnt, bus.dma_gnt, bus.mem_we, bus.mem_re, bus.mem_addr,
                bus.mem_wdata, bus.cpu_rvalid, bus.cpu_rdata, bus.dma_rvalid, bus.dma_rdata});
  endfunction

  task automatic drive_idle();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h00; bus.cpu_wdata = 8'h00;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_lock = 1'b0;
    bus.dma_addr = 8'h00; bus.dma_wdata = 8'h00;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_idle();
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  logic [7:0] n_dma;
  logic       cpu_done;
  logic       cg_s, dg_s;
  logic       exp_crv, exp_drv;
  logic [7:0] exp_crd, exp_drd;
  logic       ok;
  int         dma_wait;

  localparam logic [8:0] BURST_CG = 9'b000001000;  // index 0 = leftmost
  localparam logic [8:0] BURST_DG = 9'b111110111;
  localparam logic [5:0] DROP_CG  = 6'b111110;
  localparam logic [5:0] DROP_DG  = 6'b000001;

  initial begin
    checks   = 0;
    failures = 0;
    preload  = 1'b1;
    reset    = 1'b1;
    drive_idle();
    next_cycle();
    next_cycle();
    preload = 1'b0;
    reset   = 1'b0;

    // Directed vectors: single reads, interleaved reads, contention, writes
    vecs[0]  = '{1'b1, 2'b10, 8'h10, 8'h00, 3'b000, 8'h00, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 2'b10, 8'h10, 8'h00, 3'b000, 8'h00, 8'h00, 4'b1001, 8'h10, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 2'b00, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b1, 8'h5A, 1'b0, 8'h00};
    vecs[3]  = '{1'b0, 2'b10, 8'h01, 8'h00, 3'b000, 8'h00, 8'h00, 4'b1001, 8'h01, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[4]  = '{1'b0, 2'b00, 8'h00, 8'h00, 3'b100, 8'h02, 8'h00, 4'b0101, 8'h02, 8'h00, 1'b1, 8'h11, 1'b0, 8'h00};
    vecs[5]  = '{1'b0, 2'b00, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 8'h22};
    vecs[6]  = '{1'b0, 2'b10, 8'h10, 8'h00, 3'b100, 8'h30, 8'h00, 4'b1001, 8'h10, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[7]  = '{1'b0, 2'b10, 8'h10, 8'h00, 3'b100, 8'h30, 8'h00, 4'b1001, 8'h10, 8'h00, 1'b1, 8'h5A, 1'b0, 8'h00};
    vecs[8]  = vecs[7];
    vecs[9]  = vecs[7];
    vecs[10] = '{1'b0, 2'b10, 8'h10, 8'h00, 3'b100, 8'h30, 8'h00, 4'b0101, 8'h30, 8'h00, 1'b1, 8'h5A, 1'b0, 8'h00};
    vecs[11] = '{1'b0, 2'b10, 8'h10, 8'h00, 3'b100, 8'h30, 8'h00, 4'b1001, 8'h10, 8'h00, 1'b0, 8'h00, 1'b1, 8'h33};
    vecs[12] = vecs[7];
    vecs[13] = vecs[7];
    vecs[14] = vecs[7];
    vecs[15] = vecs[10];
    vecs[16] = '{1'b0, 2'b00, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 8'h33};
    vecs[17] = '{1'b0, 2'b11, 8'h40, 8'h77, 3'b000, 8'h00, 8'h00, 4'b1010, 8'h40, 8'h77, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[18] = '{1'b0, 2'b00, 8'h00, 8'h00, 3'b100, 8'h40, 8'h00, 4'b0101, 8'h40, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[19] = '{1'b0, 2'b00, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 8'h77};
    vecs[20] = '{1'b0, 2'b00, 8'h00, 8'h00, 3'b110, 8'h41, 8'h99, 4'b0110, 8'h41, 8'h99, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[21] = '{1'b0, 2'b10, 8'h41, 8'h00, 3'b000, 8'h00, 8'h00, 4'b1001, 8'h41, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[22] = '{1'b0, 2'b00, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b1, 8'h99, 1'b0, 8'h00};

    for (int i = 0; i < 23; i++) begin
      reset         = vecs[i].rst;
      bus.cpu_req   = vecs[i].cpu_rw[1];
      bus.cpu_we    = vecs[i].cpu_rw[0];
      bus.cpu_addr  = vecs[i].cpu_addr;
      bus.cpu_wdata = vecs[i].cpu_wdata;
      bus.dma_req   = vecs[i].dma_rwl[2];
      bus.dma_we    = vecs[i].dma_rwl[1];
      bus.dma_lock  = vecs[i].dma_rwl[0];
      bus.dma_addr  = vecs[i].dma_addr;
      bus.dma_wdata = vecs[i].dma_wdata;
      @(negedge clock);
      chk($sformatf("vec%0d", i), observed(),
          64'({vecs[i].strb, vecs[i].maddr, vecs[i].mwdata,
               vecs[i].crv, vecs[i].crd, vecs[i].drv, vecs[i].drd}));
      next_cycle();
    end

    // Locked DMA burst writes with a CPU request arriving one cycle later
    do_reset();
    n_dma    = 8'd0;
    cpu_done = 1'b0;
    for (int c = 0; c < 9; c++) begin
      bus.dma_req   = 1'b1;
      bus.dma_lock  = 1'b1;
      bus.dma_we    = 1'b1;
      bus.dma_addr  = 8'h20 + n_dma;
      bus.dma_wdata = 8'hA0 + n_dma;
      bus.cpu_req   = (c >= 1) && !cpu_done;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = 8'h10;
      @(negedge clock);
      chk($sformatf("burst_gnt%0d", c), 64'({bus.cpu_gnt, bus.dma_gnt}),
          64'({BURST_CG[8-c], BURST_DG[8-c]}));
      cg_s = bus.cpu_gnt;
      dg_s = bus.dma_gnt;
      next_cycle();
      if (dg_s) n_dma = n_dma + 8'd1;
      if (cg_s) cpu_done = 1'b1;
    end
    drive_idle();
    next_cycle();
    for (int k = 0; k < 8; k++)
      chk($sformatf("burst_mem%0d", k), 64'(mem[8'h20 + k]), 64'(8'hA0 + k));

    // DMA request dropped for one cycle: wait count holds, it does not grow
    do_reset();
    for (int c = 0; c < 6; c++) begin
      bus.cpu_req  = 1'b1;
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = 8'h10;
      bus.dma_req  = (c != 3);
      bus.dma_we   = 1'b0;
      bus.dma_lock = 1'b0;
      bus.dma_addr = 8'h30;
      @(negedge clock);
      chk($sformatf("drop_gnt%0d", c), 64'({bus.cpu_gnt, bus.dma_gnt}),
          64'({DROP_CG[5-c], DROP_DG[5-c]}));
      next_cycle();
    end

    // Reset the cycle after a granted DMA read drops the pending return
    drive_idle();
    bus.dma_req  = 1'b1;
    bus.dma_addr = 8'h30;
    @(negedge clock);
    chk("rst_pre_dgnt", 64'(bus.dma_gnt), 64'(1));
    next_cycle();
    reset        = 1'b1;
    bus.dma_req  = 1'b0;
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 8'h10;
    @(negedge clock);
    chk("rst_outputs", observed(), 64'(0));
    next_cycle();
    reset = 1'b0;
    @(negedge clock);
    chk("rst_after", 64'({bus.cpu_gnt, bus.dma_rvalid}), 64'({1'b1, 1'b0}));
    next_cycle();
    bus.cpu_req = 1'b0;
    @(negedge clock);
    chk("rst_cpu_rd", 64'({bus.cpu_rvalid, bus.cpu_rdata, bus.dma_rvalid}),
        64'({1'b1, 8'h5A, 1'b0}));
    next_cycle();

    // Random traffic against the memory model scoreboard
    drive_idle();
    exp_crv  = 1'b0; exp_drv = 1'b0;
    exp_crd  = 8'h00; exp_drd = 8'h00;
    dma_wait = 0;
    for (int c = 0; c < 10000; c++) begin
      if (!bus.cpu_req && ($urandom_range(0, 1) == 1)) begin
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'($urandom_range(0, 1));
        bus.cpu_addr  = 8'($urandom_range(0, 31));
        bus.cpu_wdata = 8'($urandom);
      end
      if (!bus.dma_req && ($urandom_range(0, 1) == 1)) begin
        bus.dma_req   = 1'b1;
        bus.dma_we    = 1'($urandom_range(0, 1));
        bus.dma_addr  = 8'($urandom_range(0, 31));
        bus.dma_wdata = 8'($urandom);
      end
      bus.dma_lock = bus.dma_req && ($urandom_range(0, 3) != 0);
      @(negedge clock);
      if (exp_crv || exp_drv || bus.cpu_rvalid || bus.dma_rvalid)
        chk("rand_rd", 64'({bus.cpu_rvalid, bus.cpu_rdata, bus.dma_rvalid, bus.dma_rdata}),
            64'({exp_crv, exp_crd, exp_drv, exp_drd}));
      if (bus.dma_req && !bus.dma_gnt) dma_wait++;
      else                             dma_wait = 0;
      ok = !(bus.cpu_gnt && bus.dma_gnt)
        && (!bus.cpu_gnt || bus.cpu_req) && (!bus.dma_gnt || bus.dma_req)
        && (bus.mem_addr == (bus.cpu_gnt ? bus.cpu_addr : bus.dma_gnt ? bus.dma_addr : 8'h00))
        && (bus.mem_we == ((bus.cpu_gnt && bus.cpu_we) || (bus.dma_gnt && bus.dma_we)))
        && (bus.mem_re == ((bus.cpu_gnt && !bus.cpu_we) || (bus.dma_gnt && !bus.dma_we)))
        && (dma_wait <= MAX_WAIT + 1);
      chk("rand_inv", 64'(ok), 64'(1));
      exp_crv = bus.cpu_gnt && !bus.cpu_we;
      exp_drv = bus.dma_gnt && !bus.dma_we;
      exp_crd = exp_crv ? mem[bus.mem_addr] : 8'h00;
      exp_drd = exp_drv ? mem[bus.mem_addr] : 8'h00;
      cg_s = bus.cpu_gnt;
      dg_s = bus.dma_gnt;
      next_cycle();
      if (cg_s) bus.cpu_req = 1'b0;
      if (dg_s) bus.dma_req = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
